// File: rtl/aes128_cbc_top.sv
// Iterative AES-128 single-block CBC engine: encrypts P xor IV one round per
// clock, then decrypts its own ciphertext back using the stored round keys.
// Free-running 21-cycle period: LOAD (1), ENC (10), DEC (10).
module aes128_cbc_top (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] key_0,
  input  logic [31:0] key_1,
  input  logic [31:0] key_2,
  input  logic [31:0] key_3,
  input  logic [31:0] vector_0,
  input  logic [31:0] vector_1,
  input  logic [31:0] vector_2,
  input  logic [31:0] vector_3,
  input  logic [31:0] plain_text_0,
  input  logic [31:0] plain_text_1,
  input  logic [31:0] plain_text_2,
  input  logic [31:0] plain_text_3,
  output logic [31:0] cipher_text_0,
  output logic [31:0] cipher_text_1,
  output logic [31:0] cipher_text_2,
  output logic [31:0] cipher_text_3,
  output logic [31:0] decrypted_plain_text_0,
  output logic [31:0] decrypted_plain_text_1,
  output logic [31:0] decrypted_plain_text_2,
  output logic [31:0] decrypted_plain_text_3
);

  typedef enum logic [1:0] {LOAD, ENC, DEC} state_t;

  state_t       state, state_next;
  logic [3:0]   counter;
  logic [3:0]   prev_idx;
  logic [127:0] enc_state, dec_state, iv_reg;
  logic [127:0] cipher_reg, plain_reg;
  logic [127:0] rk [0:10];
  logic [127:0] rk_new, enc_next, dec_next;
  logic [127:0] key_in, iv_in, pt_in;

  assign key_in = {key_3, key_2, key_1, key_0};
  assign iv_in  = {vector_3, vector_2, vector_1, vector_0};
  assign pt_in  = {plain_text_3, plain_text_2, plain_text_1, plain_text_0};

  // GF(2^8) helpers over polynomial 0x11B
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as b^254 (square-and-multiply); maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] b);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, b);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x;
    x = gf_inv(b);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Next round key from the previous one (RotWord, SubWord, Rcon on word 0)
  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // SubBytes, ShiftRows, MixColumns (skipped when last), AddRoundKey
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   sb [0:15];
    logic [7:0]   sr [0:15];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
      else      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o ^ k;
  endfunction

  // InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns (skipped when last)
  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [127:0] x, o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        x[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    x = x ^ k;
    o = x;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = x[127-32*c -: 8];
        a1 = x[119-32*c -: 8];
        a2 = x[111-32*c -: 8];
        a3 = x[103-32*c -: 8];
        o[127-32*c -: 32] = {
          gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3),
          gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3),
          gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3),
          gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3)};
      end
    end
    return o;
  endfunction

  // Round datapath; prev_idx guards the counter=0 case outside ENC
  assign prev_idx = (counter == 4'd0) ? 4'd0 : counter - 4'd1;
  assign rk_new   = key_expand(rk[prev_idx], rcon(counter));
  assign enc_next = enc_round(enc_state, rk_new, counter == 4'd10);
  assign dec_next = dec_round(dec_state, rk[counter], counter == 4'd0);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  // FSM next-state: LOAD -> ENC after one cycle, ENC -> DEC after round 10, DEC -> LOAD at round 0
  always_comb begin
    state_next = state;
    case (state)
      LOAD:    state_next = ENC;
      ENC:     if (counter == 4'd10) state_next = DEC;
      DEC:     if (counter == 4'd0)  state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Datapath registers: capture, round iteration, key storage and result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      counter    <= 4'd0;
      enc_state  <= '0;
      dec_state  <= '0;
      iv_reg     <= '0;
      cipher_reg <= '0;
      plain_reg  <= '0;
      for (int i = 0; i < 11; i++) rk[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          enc_state <= pt_in ^ iv_in ^ key_in;
          iv_reg    <= iv_in;
          rk[0]     <= key_in;
          counter   <= 4'd1;
        end
        ENC: begin
          rk[counter] <= rk_new;
          enc_state   <= enc_next;
          if (counter == 4'd10) begin
            cipher_reg <= enc_next;
            dec_state  <= enc_next ^ rk_new;
            counter    <= 4'd9;
          end else begin
            counter <= counter + 4'd1;
          end
        end
        DEC: begin
          dec_state <= dec_next;
          if (counter == 4'd0) plain_reg <= dec_next ^ iv_reg;
          else                 counter   <= counter - 4'd1;
        end
        default: counter <= 4'd0;
      endcase
    end
  end

  assign {cipher_text_3, cipher_text_2, cipher_text_1, cipher_text_0} = cipher_reg;
  assign {decrypted_plain_text_3, decrypted_plain_text_2,
          decrypted_plain_text_1, decrypted_plain_text_0} = plain_reg;

endmodule

// File: tb/tb_aes128_cbc_top.sv
// Bench for aes128_cbc_top: known-answer vectors, reset behaviour, input
// isolation outside LOAD and random back-to-back blocks against a
// table-driven AES-128 encryption model.
module tb_aes128_cbc_top;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] key_0, key_1, key_2, key_3;
  logic [31:0] vector_0, vector_1, vector_2, vector_3;
  logic [31:0] plain_text_0, plain_text_1, plain_text_2, plain_text_3;
  logic [31:0] cipher_text_0, cipher_text_1, cipher_text_2, cipher_text_3;
  logic [31:0] decrypted_plain_text_0, decrypted_plain_text_1;
  logic [31:0] decrypted_plain_text_2, decrypted_plain_text_3;
  logic [127:0] c_out, d_out;

  logic [127:0] exp_c_q[$];
  logic [127:0] exp_d_q[$];
  logic [7:0]   sbox_t [0:255];
  int checks = 0;
  int failures = 0;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] IV1 = 128'h0;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C2  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] K3  = 128'h100F0E0D0C0B0A090807060504030201;
  localparam logic [127:0] IV3 = 128'h0102030405060708090A0B0C0D0E0F10;
  localparam logic [127:0] P3  = 128'h54494d47206e616c6f4e20726f6e6f43;

  // Clock
  always #5 clk = ~clk;

  aes128_cbc_top dut (
    .clk(clk), .reset(reset),
    .key_0(key_0), .key_1(key_1), .key_2(key_2), .key_3(key_3),
    .vector_0(vector_0), .vector_1(vector_1), .vector_2(vector_2), .vector_3(vector_3),
    .plain_text_0(plain_text_0), .plain_text_1(plain_text_1),
    .plain_text_2(plain_text_2), .plain_text_3(plain_text_3),
    .cipher_text_0(cipher_text_0), .cipher_text_1(cipher_text_1),
    .cipher_text_2(cipher_text_2), .cipher_text_3(cipher_text_3),
    .decrypted_plain_text_0(decrypted_plain_text_0),
    .decrypted_plain_text_1(decrypted_plain_text_1),
    .decrypted_plain_text_2(decrypted_plain_text_2),
    .decrypted_plain_text_3(decrypted_plain_text_3)
  );

  assign c_out = {cipher_text_3, cipher_text_2, cipher_text_1, cipher_text_0};
  assign d_out = {decrypted_plain_text_3, decrypted_plain_text_2,
                  decrypted_plain_text_1, decrypted_plain_text_0};

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box table from the generator-3 walk (p *= 3, q /= 3, affine of q)
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0]  w [0:43];
    logic [7:0]   st [0:3][0:3];
    logic [7:0]   tmp [0:3][0:3];
    logic [7:0]   rc;
    logic [31:0]  t;
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          tmp[r][c] = sbox_t[st[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rnd < 10)
            st[r][c] = gmul(8'h02, tmp[r][c]) ^ gmul(8'h03, tmp[(r+1)%4][c]) ^
                       tmp[(r+2)%4][c] ^ tmp[(r+3)%4][c];
          else
            st[r][c] = tmp[r][c];
          st[r][c] = st[r][c] ^ w[4*rnd+c][31-8*r -: 8];
        end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        out[127-8*(4*c+r) -: 8] = st[r][c];
    return out;
  endfunction

  // ---------------- driver / scoreboard access ----------------
  task automatic set_inputs(input logic [127:0] k, input logic [127:0] iv, input logic [127:0] p);
    {key_3, key_2, key_1, key_0}                         = k;
    {vector_3, vector_2, vector_1, vector_0}             = iv;
    {plain_text_3, plain_text_2, plain_text_1, plain_text_0} = p;
  endtask

  task automatic push_expect(input logic [127:0] c, input logic [127:0] p);
    exp_c_q.push_back(c);
    exp_d_q.push_back(p);
  endtask

  // An empty queue yields X so the following comparison cannot pass
  function automatic logic [127:0] pop_c();
    if (exp_c_q.size() == 0) return 'x;
    return exp_c_q.pop_front();
  endfunction

  function automatic logic [127:0] pop_d();
    if (exp_d_q.size() == 0) return 'x;
    return exp_d_q.pop_front();
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [127:0] exp;
    int first_c, first_d;
    exp_c_q.delete();
    exp_d_q.delete();
    set_inputs(K1, IV1, P1);
    push_expect(C1, P1);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({c_out, d_out} !== 256'h0) begin
        failures++;
        $display("FAIL reset_hold[%0d]: got c=%h d=%h required 0", i, c_out, d_out);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    first_c = -1;
    first_d = -1;
    for (int e = 0; e < 30; e++) begin
      tick();
      if (first_c < 0 && c_out !== 128'h0) begin
        first_c = e;
        exp = pop_c();
        checks++;
        if (c_out !== exp) begin
          failures++;
          $display("FAIL reset_first_c: got %h required %h", c_out, exp);
        end
      end
      if (first_d < 0 && d_out !== 128'h0) begin
        first_d = e;
        exp = pop_d();
        checks++;
        if (d_out !== exp) begin
          failures++;
          $display("FAIL reset_first_d: got %h required %h", d_out, exp);
        end
      end
    end
    checks++;
    if (first_c != 10) begin
      failures++;
      $display("FAIL reset_c_edge: got edge %0d required edge 10", first_c);
    end
    checks++;
    if (first_d != 20) begin
      failures++;
      $display("FAIL reset_d_edge: got edge %0d required edge 20", first_d);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] k_tab [0:6];
    logic [127:0] iv_tab [0:6];
    logic [127:0] p_tab [0:6];
    logic [127:0] c_tab [0:6];
    logic [127:0] exp, held_c, held_d;
    k_tab[0] = K1; iv_tab[0] = IV1; p_tab[0] = P1; c_tab[0] = C1;
    k_tab[1] = K2; iv_tab[1] = IV2; p_tab[1] = P2; c_tab[1] = C2;
    k_tab[2] = K3; iv_tab[2] = IV3; p_tab[2] = P3;
    c_tab[2] = model_enc(K3, P3 ^ IV3);
    for (int i = 3; i < 7; i++) begin
      k_tab[i]  = rand128();
      iv_tab[i] = rand128();
      p_tab[i]  = rand128();
      c_tab[i]  = model_enc(k_tab[i], p_tab[i] ^ iv_tab[i]);
    end
    exp_c_q.delete();
    exp_d_q.delete();
    held_c = '0;
    held_d = '0;
    set_inputs(k_tab[0], iv_tab[0], p_tab[0]);
    push_expect(c_tab[0], p_tab[0]);
    pulse_reset();
    for (int b = 0; b < 7; b++) begin
      for (int e = 0; e <= 20; e++) begin
        tick();
        if (e == 3) set_inputs(rand128(), rand128(), rand128());
        if (e == 9 || e == 19) begin
          checks++;
          if ({c_out, d_out} !== {held_c, held_d}) begin
            failures++;
            $display("FAIL b2b_hold blk%0d e%0d: got c=%h d=%h required c=%h d=%h",
                     b, e, c_out, d_out, held_c, held_d);
          end
        end
        if (e == 10) begin
          exp = pop_c();
          checks++;
          if (c_out !== exp) begin
            failures++;
            $display("FAIL b2b_cipher blk%0d: got %h required %h", b, c_out, exp);
          end
          held_c = exp;
        end
        if (e == 20) begin
          exp = pop_d();
          checks++;
          if (d_out !== exp) begin
            failures++;
            $display("FAIL b2b_decrypt blk%0d: got %h required %h", b, d_out, exp);
          end
          held_d = exp;
          if (b < 6) begin
            set_inputs(k_tab[b+1], iv_tab[b+1], p_tab[b+1]);
            push_expect(c_tab[b+1], p_tab[b+1]);
          end
        end
      end
    end
  endtask

  task automatic test_mid_dec_reset();
    logic [127:0] exp;
    exp_c_q.delete();
    exp_d_q.delete();
    set_inputs(K2, IV2, P2);
    exp_c_q.push_back(C2);
    pulse_reset();
    for (int e = 0; e <= 14; e++) begin
      tick();
      if (e == 10) begin
        exp = pop_c();
        checks++;
        if (c_out !== exp) begin
          failures++;
          $display("FAIL mid_reset_pre_c: got %h required %h", c_out, exp);
        end
      end
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({c_out, d_out} !== 256'h0) begin
      failures++;
      $display("FAIL mid_reset_clear: got c=%h d=%h required 0", c_out, d_out);
    end
    reset = 1'b0;
    push_expect(C2, P2);
    for (int e = 0; e <= 20; e++) begin
      tick();
      if (e == 9) begin
        checks++;
        if ({c_out, d_out} !== 256'h0) begin
          failures++;
          $display("FAIL mid_reset_e9: got c=%h d=%h required 0", c_out, d_out);
        end
      end
      if (e == 10) begin
        exp = pop_c();
        checks++;
        if (c_out !== exp) begin
          failures++;
          $display("FAIL mid_reset_c: got %h required %h", c_out, exp);
        end
      end
      if (e == 19) begin
        checks++;
        if (d_out !== 128'h0) begin
          failures++;
          $display("FAIL mid_reset_e19: got d=%h required 0", d_out);
        end
      end
      if (e == 20) begin
        exp = pop_d();
        checks++;
        if (d_out !== exp) begin
          failures++;
          $display("FAIL mid_reset_d: got %h required %h", d_out, exp);
        end
      end
    end
  endtask

  task automatic test_input_change();
    logic [127:0] exp, p_new;
    exp_c_q.delete();
    exp_d_q.delete();
    set_inputs(K1, IV1, P1);
    push_expect(C1, P1);
    pulse_reset();
    for (int e = 0; e <= 41; e++) begin
      tick();
      if (e == 5) begin
        p_new = rand128();
        {plain_text_3, plain_text_2, plain_text_1, plain_text_0} = p_new;
        push_expect(model_enc(K1, p_new ^ IV1), p_new);
      end
      if (e == 10 || e == 31) begin
        exp = pop_c();
        checks++;
        if (c_out !== exp) begin
          failures++;
          $display("FAIL input_change_c e%0d: got %h required %h", e, c_out, exp);
        end
      end
      if (e == 20 || e == 41) begin
        exp = pop_d();
        checks++;
        if (d_out !== exp) begin
          failures++;
          $display("FAIL input_change_d e%0d: got %h required %h", e, d_out, exp);
        end
      end
    end
  endtask

  // Watchdog: the sequence is a few hundred cycles, so this only fires on a hang
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "time limit reached");
  end

  // Test sequence and summary
  initial begin
    set_inputs('0, '0, '0);
    reset = 1'b1;
    build_sbox();
    repeat (2) @(negedge clk);
    test_reset();
    test_back_to_back();
    test_mid_dec_reset();
    test_input_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
